// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity bit for a latched data word; even or odd selectable.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WD = 8
) (
  input  logic [DATA_WD-1:0] data_i,
  input  logic               par_typ_i,
  output logic               par_bit_c_o
);

  // Even parity makes the total count of ones even; odd inverts that.
  always_comb begin
    par_bit_c_o = ^data_i;
    if (par_typ_i == PAR_ODD) begin
      par_bit_c_o = ~(^data_i);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// One i_clk cycle is one bit period; outputs are registered from the current state.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WD = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_data_valid,
  input  logic [DATA_WD-1:0] i_p_data,
  input  logic               i_par_en,
  input  logic               i_par_typ,
  output logic               o_tx_out,
  output logic               o_busy
);

  localparam int unsigned CNT_WD = $clog2(DATA_WD);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(DATA_WD - 1);

  state_e              state_q, state_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic [DATA_WD-1:0]  data_q, data_d;
  logic                par_en_q, par_en_d;
  logic                par_typ_q, par_typ_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                par_bit_c;

  uart_parity_calc #(
    .DATA_WD(DATA_WD)
  ) u_parity (
    .data_i     (data_q),
    .par_typ_i  (par_typ_q),
    .par_bit_c_o(par_bit_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, bit counter and line level; configuration latched only in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = IDLE_LEVEL;
    busy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_data_valid) begin
          data_d    = i_p_data;
          par_en_d  = i_par_en;
          par_typ_d = i_par_typ;
          state_d   = START;
        end
      end
      START: begin
        tx_d    = START_BIT;
        busy_d  = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        tx_d   = data_q[cnt_q];
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CNT_WD'(1);
        end
      end
      PARITY: begin
        tx_d    = par_bit_c;
        busy_d  = 1'b1;
        state_d = STOP;
      end
      STOP: begin
        tx_d    = STOP_BIT;
        busy_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_tx_out = tx_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized and directed bench for uart_tx_serializer against a frame-level model.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic       data_valid;
  logic [7:0] p_data;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int checks;
  int errors;
  int t;
  int next_free;
  logic [1:0] exp_q[$];

  uart_tx_serializer #(
    .DATA_WD(8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data_valid(data_valid),
    .i_p_data    (p_data),
    .i_par_en    (par_en),
    .i_par_typ   (par_typ),
    .o_tx_out    (tx_out),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s t=%0d {busy,tx} got %b want %b", tag, t, obs, expv);
    end
  endtask

  // Expected {busy,tx} per bit period of one accepted frame.
  task automatic model_accept(input logic [7:0] d, input logic pe, input logic pt);
    int len;
    exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
    if (pe) exp_q.push_back({1'b1, logic'($countones(d) % 2) ^ pt});
    exp_q.push_back(2'b11);
    len = pe ? 11 : 10;
    next_free = t + len + 1;
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic pe, input logic pt);
    logic [1:0] expv;
    @(negedge clk);
    data_valid = v;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    @(posedge clk);
    #1;
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b01;
    check(tag, {busy, tx_out}, expv);
    if (v && t >= next_free) model_accept(d, pe, pt);
    t++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_free = 0;
    t = 0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    t          = 0;
    next_free  = 0;
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;

    #12;
    check("reset_val", {busy, tx_out}, 2'b01);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle("post_reset", 3);

    step("a5_even", 1'b1, 8'hA5, 1'b1, 1'b0);
    idle("a5_even", 13);
    step("a5_odd", 1'b1, 8'hA5, 1'b1, 1'b1);
    idle("a5_odd", 13);
    step("zero_nopar", 1'b1, 8'h00, 1'b0, 1'b0);
    idle("zero_nopar", 12);

    step("ff_frame", 1'b1, 8'hFF, 1'b1, 1'b0);
    idle("ff_frame", 3);
    step("ignore_3c", 1'b1, 8'h3C, 1'b0, 1'b1);
    idle("ff_frame", 10);

    step("b2b", 1'b1, 8'h81, 1'b1, 1'b0);
    for (int i = 0; i < 26; i++) step("b2b", 1'b1, 8'h7E, 1'b1, logic'(i % 2));
    idle("b2b", 14);

    // Abort mid-frame: line must go high without waiting for a clock edge.
    step("abort", 1'b1, 8'h0F, 1'b1, 1'b1);
    idle("abort", 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {busy, tx_out}, 2'b01);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle("no_resume", 3);
    idle("no_resume", 12);

    for (int i = 0; i < 800; i++) begin
      step("random", ($urandom_range(0, 3) == 0), 8'($urandom),
           1'($urandom), 1'($urandom));
    end
    idle("drain", 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
